// File: rtl/rom_ctrl_pkg.sv
// Shared constants for the block-ROM read controller: FSM state encoding,
// default bus widths and the legal read-latency window.
package rom_ctrl_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 16;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Wide enough to hold RD_LAT_MAX-1
   localparam int CNT_W = 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   // Counter preload for the WAIT phase; an out-of-range latency is clamped
   // into the supported window so the counter can never wrap.
   function automatic logic [CNT_W-1:0] wait_load(input int rd_lat);
      int lat_c;
      if (rd_lat < RD_LAT_MIN) begin
         lat_c = RD_LAT_MIN;
      end else if (rd_lat > RD_LAT_MAX) begin
         lat_c = RD_LAT_MAX;
      end else begin
         lat_c = rd_lat;
      end
      return CNT_W'(lat_c - 1);
   endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie the requester that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   // select the winner index from the request pair and the previous grant
   always_comb begin
      any_req = |req;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Two-client arbiter and read sequencer in front of the 16x16 block ROM.
// One read is in flight at a time: IDLE grants, READ pulses the ROM enable
// for a single cycle, WAIT covers the ROM's registered latency and then
// hands the word back to the owning client with a one-cycle valid strobe.
module rom_read_arbiter
   import rom_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              busy
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(RD_LAT);

   logic [1:0]        state_r;
   logic [CNT_W-1:0]  wait_cnt_r;
   logic              owner_r;
   logic              last_grant_r;
   logic [ADDR_W-1:0] addr_q_r;

   logic [1:0]        req_s;
   logic              grant_s;
   logic              any_req_s;
   logic              start_s;
   logic              done_s;

   assign req_s    = {req1, req0};
   assign rom_addr = addr_q_r;

   rr_arb2 u_arb (
      .req        (req_s),
      .last_grant (last_grant_r),
      .grant      (grant_s),
      .any_req    (any_req_s)
   );

   // decode the two transaction events: a grant out of IDLE, completion of WAIT
   always_comb begin
      start_s = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            start_s = any_req_s;
         end
         WAIT: begin
            done_s = (wait_cnt_r == {CNT_W{1'b0}});
         end
         default: begin
            start_s = 1'b0;
            done_s  = 1'b0;
         end
      endcase
   end

   // sequencer state, latency counter and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         wait_cnt_r <= {CNT_W{1'b0}};
         busy       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= READ;
                  busy    <= 1'b1;
               end
            end
            READ: begin
               state_r    <= WAIT;
               wait_cnt_r <= WAIT_LOAD;
            end
            WAIT: begin
               if (done_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  wait_cnt_r <= wait_cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // capture the winner, its address and round-robin history; pulse ack and rom_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_r      <= 1'b0;
         last_grant_r <= 1'b1;
         addr_q_r     <= {ADDR_W{1'b0}};
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         rom_en       <= 1'b0;
      end else begin
         ack0   <= start_s & ~grant_s;
         ack1   <= start_s & grant_s;
         rom_en <= start_s;
         if (start_s) begin
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            addr_q_r     <= grant_s ? addr1 : addr0;
         end
      end
   end

   // return the ROM word to the owning client only; the other client's data holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0  <= {DATA_W{1'b0}};
         rdata1  <= {DATA_W{1'b0}};
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= done_s & ~owner_r;
         rvalid1 <= done_s & owner_r;
         if (done_s & ~owner_r) begin
            rdata0 <= rom_dout;
         end
         if (done_s & owner_r) begin
            rdata1 <= rom_dout;
         end
      end
   end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: two instances (read latency 1 and 3), each with
// its own ROM model and clients, checked every cycle against a timeline model
// that predicts grants, acks, enables and responses from the arbitration rules.
module tb_rom_read_arbiter;

   int n_cmp = 0;
   int n_bad = 0;
   logic clk;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : cfg
      localparam int LAT = (gi == 0) ? 1 : 3;

      logic        rst_n, req0, req1;
      logic [3:0]  addr0, addr1, rom_addr;
      logic        ack0, ack1, rvalid0, rvalid1, rom_en, busy;
      logic [15:0] rdata0, rdata1, rom_dout;
      logic [15:0] pipe [3];
      bit          fin;

      // timeline model state
      int          cyc, g_at, free_at, last_en;
      bit          last, own, hold0, hold1;
      logic [3:0]  gaddr;
      logic [15:0] e_rd0, e_rd1;
      bit          q_ack [$];
      logic [15:0] rv1q [$];

      rom_read_arbiter #(.ADDR_W(4), .DATA_W(16), .RD_LAT(LAT)) dut (
         .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
         .addr0(addr0), .addr1(addr1), .ack0(ack0), .ack1(ack1),
         .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
         .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
      );

      // ROM model: word = A000|addr, valid LAT cycles after the enable edge
      always @(posedge clk) begin
         pipe[0] <= rom_en ? (16'hA000 | {12'h000, rom_addr}) : pipe[0];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign rom_dout = pipe[LAT-1];

      function automatic string tg(input string s);
         return $sformatf("lat%0d.%s", LAT, s);
      endfunction

      task automatic model_reset();
         cyc = 0; g_at = -100; free_at = 0; last_en = -1;
         last = 1'b1; own = 1'b0; gaddr = 4'h0;
         e_rd0 = 16'h0000; e_rd1 = 16'h0000;
      endtask

      task automatic model_edge();
         bit win;
         cyc++;
         if (cyc == g_at + 1 + LAT) begin
            if (own) e_rd1 = 16'hA000 | {12'h000, gaddr};
            else     e_rd0 = 16'hA000 | {12'h000, gaddr};
         end
         if (cyc >= free_at && (req0 || req1)) begin
            win = (req0 && req1) ? !last : req1;
            last = win; own = win; g_at = cyc;
            free_at = cyc + 2 + LAT;
            gaddr = win ? addr1 : addr0;
         end
      endtask

      task automatic compare();
         bit gnow, dnow, bnow;
         gnow = (g_at == cyc);
         dnow = (cyc == g_at + 1 + LAT);
         bnow = (cyc >= g_at) && (cyc <= g_at + LAT);
         chk(tg("ack0"),     32'(ack0),     32'(gnow && !own));
         chk(tg("ack1"),     32'(ack1),     32'(gnow && own));
         chk(tg("rom_en"),   32'(rom_en),   32'(gnow));
         chk(tg("rom_addr"), 32'(rom_addr), 32'(gaddr));
         chk(tg("busy"),     32'(busy),     32'(bnow));
         chk(tg("rvalid0"),  32'(rvalid0),  32'(dnow && !own));
         chk(tg("rvalid1"),  32'(rvalid1),  32'(dnow && own));
         chk(tg("rdata0"),   32'(rdata0),   32'(e_rd0));
         chk(tg("rdata1"),   32'(rdata1),   32'(e_rd1));
      endtask

      task automatic step();
         @(posedge clk);
         if (rst_n) model_edge();
         @(negedge clk);
         compare();
         if (rom_en) begin
            if (last_en >= 0) chk(tg("en_gap"), 32'((cyc - last_en) >= LAT + 2), 32'd1);
            last_en = cyc;
         end
         if (ack0) begin q_ack.push_back(1'b0); if (!hold0) req0 = 1'b0; end
         if (ack1) begin q_ack.push_back(1'b1); if (!hold1) req1 = 1'b0; end
         if (rvalid1) rv1q.push_back(rdata1);
      endtask

      task automatic wait_ack(input bit who, input int maxc);
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < maxc && !seen; i++) begin
            step();
            seen = who ? ack1 : ack0;
         end
         chk(tg("ack_wait"), 32'(seen), 32'd1);
      endtask

      task automatic run_idle(input int maxc);
         bit idle;
         idle = 1'b0;
         for (int i = 0; i < maxc && !idle; i++) begin
            step();
            idle = !req0 && !req1 && !busy;
         end
         chk(tg("idle_wait"), 32'(idle), 32'd1);
      endtask

      initial begin
         fin = 1'b0; rst_n = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
         req0 = 1'b0; req1 = 1'b0; addr0 = 4'h0; addr1 = 4'h0;
         model_reset();
         repeat (2) @(negedge clk);
         compare();

         // both clients request straight out of reset: client 0 first
         req0 = 1'b1; addr0 = 4'h3; req1 = 1'b1; addr1 = 4'hC;
         rst_n = 1'b1;
         q_ack.delete();
         run_idle(30);
         chk(tg("tie_grants"), 32'(q_ack.size()), 32'd2);
         chk(tg("tie_first"),  32'((q_ack.size() > 0) ? q_ack[0] : 1'b1), 32'd0);
         chk(tg("tie_second"), 32'((q_ack.size() > 1) ? q_ack[1] : 1'b0), 32'd1);
         chk(tg("tie_rdata0"), 32'(rdata0), 32'h0000A003);
         chk(tg("tie_rdata1"), 32'(rdata1), 32'h0000A00C);

         // single request from client 0
         req0 = 1'b1; addr0 = 4'h5; q_ack.delete();
         run_idle(20);
         chk(tg("single_grants"), 32'(q_ack.size()), 32'd1);
         chk(tg("single_rdata0"), 32'(rdata0), 32'h0000A005);
         chk(tg("single_rdata1"), 32'(rdata1), 32'h0000A00C);

         // fairness: both held through 8 grants
         hold0 = 1'b1; hold1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
         addr0 = 4'h1; addr1 = 4'h2; q_ack.delete();
         for (int i = 0; i < 8 * (LAT + 2) + 10 && q_ack.size() < 8; i++) step();
         chk(tg("fair_cnt"), 32'(q_ack.size() >= 8), 32'd1);
         hold0 = 1'b0; hold1 = 1'b0;
         run_idle(40);
         for (int i = 1; i < q_ack.size(); i++)
            chk(tg("alternate"), 32'(q_ack[i]), 32'(!q_ack[i-1]));

         // client 1 arrives while client 0 is waiting on the ROM
         req0 = 1'b1; addr0 = 4'h2;
         wait_ack(1'b0, 10);
         step();
         req1 = 1'b1; addr1 = 4'h7;
         run_idle(30);
         chk(tg("holdoff_rdata1"), 32'(rdata1), 32'h0000A007);

         // client 1 sweeps every address back to back
         rv1q.delete();
         for (int a = 0; a < 16; a++) begin
            req1 = 1'b1; addr1 = 4'(a);
            wait_ack(1'b1, 3 * LAT + 8);
         end
         run_idle(20);
         chk(tg("sweep_cnt"), 32'(rv1q.size()), 32'd16);
         for (int a = 0; a < rv1q.size(); a++)
            chk(tg("sweep"), 32'(rv1q[a]), 32'h0000A000 | 32'(a));

         // random clients that respect the req/ack protocol
         hold0 = 1'b1; hold1 = 1'b1;
         for (int i = 0; i < 400; i++) begin
            step();
            if (req0 && ack0) begin
               if ($urandom % 2 == 0) req0 = 1'b0; else addr0 = 4'($urandom);
            end else if (!req0 && ($urandom % 3 == 0)) begin
               req0 = 1'b1; addr0 = 4'($urandom);
            end
            if (req1 && ack1) begin
               if ($urandom % 2 == 0) req1 = 1'b0; else addr1 = 4'($urandom);
            end else if (!req1 && ($urandom % 3 == 0)) begin
               req1 = 1'b1; addr1 = 4'($urandom);
            end
         end
         hold0 = 1'b0; hold1 = 1'b0;
         run_idle(80);

         // reset while a read is in WAIT: outputs clear at once, no rvalid follows
         req0 = 1'b1; addr0 = 4'h9;
         wait_ack(1'b0, 10);
         step();
         rst_n = 1'b0;
         #1;
         model_reset();
         compare();
         repeat (3) step();
         rst_n = 1'b1;
         req0 = 1'b1; addr0 = 4'hF;
         run_idle(20);
         chk(tg("post_reset_rdata0"), 32'(rdata0), 32'h0000A00F);
         fin = 1'b1;
      end
   end

   initial begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         ok = cfg[0].fin && cfg[1].fin;
      end
      chk("finish", 32'(ok), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
